// File: rtl/bus_responder.sv
// bus_responder: target end of the 8-bit rdy/ack bus. Assembles a 24-bit
// address from byte commands, performs one memory or character-I/O access
// per data command, returns read data and completes a 4-phase handshake.
module bus_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rdy,
    input  logic [2:0]        bus_ctrl,
    input  logic [7:0]        bus_din,
    output logic [7:0]        bus_dout,
    output logic              ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_done,
    output logic [7:0]        cout_data,
    output logic              cout_valid,
    input  logic              cout_ready,
    input  logic [7:0]        cin_data,
    input  logic              cin_valid,
    output logic              cin_ready,
    output logic              err
);

    localparam logic [2:0] CMD_ADDR0 = 3'd0;
    localparam logic [2:0] CMD_ADDR1 = 3'd1;
    localparam logic [2:0] CMD_ADDR2 = 3'd2;
    localparam logic [2:0] CMD_RDATA = 3'd3;
    localparam logic [2:0] CMD_WDATA = 3'd4;
    localparam logic [2:0] CMD_RCHAR = 3'd5;
    localparam logic [2:0] CMD_WCHAR = 3'd6;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EXEC      = 3'd1,
        MEM_WAIT  = 3'd2,
        COUT_WAIT = 3'd3,
        CIN_WAIT  = 3'd4,
        ACK_HOLD  = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rdy_s;
    logic [2:0]             ctrl_q;
    logic [7:0]             din_q;

    logic [7:0]        bus_dout_nxt;
    logic              ack_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [7:0]        mem_wdata_nxt;
    logic              mem_req_nxt;
    logic              mem_we_nxt;
    logic [7:0]        cout_data_nxt;
    logic              cout_valid_nxt;
    logic              cin_ready_nxt;
    logic              err_nxt;

    assign rdy_s = sync_q[SYNC_STAGES-1];

    // rdy synchronizer chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rdy};
    end

    // capture command and byte when a request is first seen in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= 3'd0;
            din_q  <= 8'd0;
        end else if (state == IDLE && rdy_s) begin
            ctrl_q <= bus_ctrl;
            din_q  <= bus_din;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (rdy_s) state_nxt = EXEC;
            EXEC: begin
                case (ctrl_q)
                    CMD_RDATA, CMD_WDATA: state_nxt = MEM_WAIT;
                    CMD_RCHAR:            state_nxt = CIN_WAIT;
                    CMD_WCHAR:            state_nxt = COUT_WAIT;
                    default:              state_nxt = ACK_HOLD;
                endcase
            end
            MEM_WAIT:  if (mem_done)   state_nxt = ACK_HOLD;
            COUT_WAIT: if (cout_ready) state_nxt = ACK_HOLD;
            CIN_WAIT:  if (cin_valid)  state_nxt = ACK_HOLD;
            ACK_HOLD:  if (!rdy_s)     state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        ack_nxt        = (state_nxt == ACK_HOLD);
        mem_req_nxt    = (state_nxt == MEM_WAIT);
        cout_valid_nxt = (state_nxt == COUT_WAIT);
        mem_we_nxt     = 1'b0;
        cin_ready_nxt  = 1'b0;
        bus_dout_nxt   = bus_dout;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        cout_data_nxt  = cout_data;
        err_nxt        = err;
        case (state)
            EXEC: begin
                case (ctrl_q)
                    CMD_ADDR0: mem_addr_nxt[7:0]   = din_q;
                    CMD_ADDR1: mem_addr_nxt[15:8]  = din_q;
                    CMD_ADDR2: mem_addr_nxt[23:16] = din_q;
                    CMD_RDATA: mem_we_nxt = 1'b0;
                    CMD_WDATA: begin
                        mem_wdata_nxt = din_q;
                        mem_we_nxt    = 1'b1;
                    end
                    CMD_WCHAR: cout_data_nxt = din_q;
                    CMD_RCHAR: ;
                    default: begin
                        err_nxt      = 1'b1;
                        bus_dout_nxt = 8'hFF;
                    end
                endcase
            end
            MEM_WAIT: begin
                mem_we_nxt = mem_we & ~mem_done;
                if (mem_done && !mem_we) bus_dout_nxt = mem_rdata;
            end
            CIN_WAIT: begin
                if (cin_valid) begin
                    bus_dout_nxt  = cin_data;
                    cin_ready_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_dout   <= 8'd0;
            ack        <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            cout_data  <= 8'd0;
            cout_valid <= 1'b0;
            cin_ready  <= 1'b0;
            err        <= 1'b0;
        end else begin
            bus_dout   <= bus_dout_nxt;
            ack        <= ack_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            cout_data  <= cout_data_nxt;
            cout_valid <= cout_valid_nxt;
            cin_ready  <= cin_ready_nxt;
            err        <= err_nxt;
        end
    end

endmodule
